// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {SCAN, DEB_PRESS, PRESSED, DEB_REL} state_e;

  localparam int ROWS = 4;
  localparam int COLS = 4;

  // All lines high: no row driven / no column pulled low.
  localparam logic [3:0] ROW_IDLE = 4'b1111;

  // Lowest-index active-low column wins when several are down.
  function automatic logic [1:0] first_low(input logic [COLS-1:0] col);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = COLS - 1; i >= 0; i--)
      if (!col[i]) idx = 2'(i);
    return idx;
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Free-running divider: one-cycle tick every SCAN_DIV clkin cycles.
module scan_tick_gen #(
  parameter int SCAN_DIV = 50000
) (
  input  logic clkin,
  input  logic reset,
  output logic tick
);

  localparam int W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  logic [W-1:0] div_cnt_q, div_cnt_d;

  // Tick on the terminal count, then wrap to zero.
  always_comb begin
    tick      = (div_cnt_q == W'(SCAN_DIV - 1));
    div_cnt_d = tick ? '0 : div_cnt_q + W'(1);
  end

  // Divider register.
  always_ff @(posedge clkin) begin
    if (reset) div_cnt_q <= '0;
    else       div_cnt_q <= div_cnt_d;
  end

endmodule

// File: rtl/keypad_scan4x4.sv
// 4x4 matrix keypad scanner with press/release debounce and a 32-bit
// digit shift register feeding the 7-segment display driver.
// Optional: define KEYPAD_CLR_KEY_EN to make key F clear data_out.
module keypad_scan4x4
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_TICKS = 16
) (
  input  logic        clkin,
  input  logic        reset,
  input  logic [3:0]  col_in,
  output logic [3:0]  row_out,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic        key_held,
  output logic [31:0] data_out
);

  localparam int DW = (DEBOUNCE_TICKS > 2) ? $clog2(DEBOUNCE_TICKS) : 1;
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_TICKS - 1);

  logic          tick;
  logic [3:0]    sync1_q, col_s_q;
  state_e        state_q, state_d;
  logic [1:0]    row_q, row_d, col_q, col_d;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  logic [3:0]    key_code_q, key_code_d;
  logic          key_valid_q, key_valid_d;
  logic          key_held_q, key_held_d;
  logic [31:0]   data_q, data_d;
  logic          col_low;
  logic [3:0]    code;

  scan_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
    .clkin (clkin),
    .reset (reset),
    .tick  (tick)
  );

  // Two-flop synchroniser on the asynchronous column inputs.
  always_ff @(posedge clkin) begin
    if (reset) begin
      sync1_q <= ROW_IDLE;
      col_s_q <= ROW_IDLE;
    end else begin
      sync1_q <= col_in;
      col_s_q <= sync1_q;
    end
  end

  // Scan/debounce next-state logic; only acts on scan ticks.
  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    deb_cnt_d   = deb_cnt_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    data_d      = data_q;
    col_low     = !col_s_q[col_q];
    code        = {row_q, col_q};
    if (tick) begin
      unique case (state_q)
        SCAN: begin
          if (col_s_q != ROW_IDLE) begin
            col_d     = first_low(col_s_q);
            deb_cnt_d = '0;
            state_d   = DEB_PRESS;
          end else begin
            row_d = row_q + 2'd1;
          end
        end
        DEB_PRESS: begin
          if (!col_low) begin
            state_d = SCAN;
          end else if (deb_cnt_q == DEB_LAST) begin
            state_d     = PRESSED;
            key_valid_d = 1'b1;
            key_code_d  = code;
`ifdef KEYPAD_CLR_KEY_EN
            data_d = (code == 4'hF) ? 32'h0 : {data_q[27:0], code};
`else
            data_d = {data_q[27:0], code};
`endif
          end else begin
            deb_cnt_d = deb_cnt_q + DW'(1);
          end
        end
        PRESSED: begin
          if (!col_low) begin
            deb_cnt_d = '0;
            state_d   = DEB_REL;
          end
        end
        DEB_REL: begin
          if (col_low) begin
            state_d = PRESSED;
          end else if (deb_cnt_q == DEB_LAST) begin
            state_d = SCAN;
            row_d   = row_q + 2'd1;
          end else begin
            deb_cnt_d = deb_cnt_q + DW'(1);
          end
        end
        default: state_d = SCAN;
      endcase
    end
    key_held_d = (state_d == PRESSED) || (state_d == DEB_REL);
  end

  // FSM and registered outputs.
  always_ff @(posedge clkin) begin
    if (reset) begin
      state_q     <= SCAN;
      row_q       <= 2'd0;
      col_q       <= 2'd0;
      deb_cnt_q   <= '0;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
      data_q      <= 32'h0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      deb_cnt_q   <= deb_cnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
      data_q      <= data_d;
    end
  end

  // One active-low row line per scanned row.
  always_comb row_out = ~(4'b0001 << row_q);

  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;
  assign data_out  = data_q;

endmodule

// File: tb/tb_keypad_scan4x4.sv
// Directed bench for keypad_scan4x4 with a behavioural 4x4 key matrix.
module tb_keypad_scan4x4;

  logic        clkin = 1'b0;
  logic        reset;
  logic [3:0]  col_in;
  logic [3:0]  row_out;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [31:0] data_out;

  logic [15:0] keys = '0;
  int          n_vec = 0;
  int          n_err = 0;
  int          pulses = 0;
  logic [31:0] exp_data;

  keypad_scan4x4 #(.SCAN_DIV(4), .DEBOUNCE_TICKS(3)) dut (
    .clkin     (clkin),
    .reset     (reset),
    .col_in    (col_in),
    .row_out   (row_out),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held),
    .data_out  (data_out)
  );

  always #5 clkin = ~clkin;

  // Key matrix: a pressed key pulls its column low while its row is driven.
  always_comb begin
    col_in = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[4*r+c] && !row_out[r]) col_in[c] = 1'b0;
  end

  always @(posedge clkin) if (key_valid) pulses <= pulses + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clkin); reset = 1'b1;
    @(negedge clkin); reset = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    bit got = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clkin);
      if (key_valid) begin got = 1; break; end
    end
    chk(tag, 32'(got), 32'd1);
  endtask

  task automatic wait_release(input string tag);
    bit got = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clkin);
      if (!key_held) begin got = 1; break; end
    end
    chk(tag, 32'(got), 32'd1);
  endtask

  task automatic press_key(input int k);
    int p0 = pulses;
    keys[k] = 1'b1;
    wait_valid("press_tmo");
    chk("key_code", 32'(key_code), 32'(k));
    chk("held_on", 32'(key_held), 32'd1);
`ifdef KEYPAD_CLR_KEY_EN
    exp_data = (k == 15) ? 32'h0 : {exp_data[27:0], 4'(k)};
`else
    exp_data = {exp_data[27:0], 4'(k)};
`endif
    chk("data", data_out, exp_data);
    keys[k] = 1'b0;
    wait_release("rel_tmo");
    chk("one_pulse", 32'(pulses), 32'(p0 + 1));
  endtask

  initial begin
    logic [3:0] row_seq [4];
    int seq [9];
    int p0;
    row_seq = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
    seq = '{1, 2, 3, 10, 11, 12, 13, 14, 0};
    reset = 1'b1;
    exp_data = 32'h0;
    repeat (2) @(negedge clkin);
    chk("rst_row", 32'(row_out), 32'h0000000E);
    chk("rst_code", 32'(key_code), 32'h0);
    chk("rst_valid", 32'(key_valid), 32'h0);
    chk("rst_held", 32'(key_held), 32'h0);
    chk("rst_data", data_out, 32'h0);
    reset = 1'b0;

    // Idle row cycling, one step per 4 cycles.
    for (int i = 0; i < 4; i++) begin
      repeat (3) @(negedge clkin);
      chk("row_hold", 32'(row_out), 32'(i == 0 ? 4'b1110 : row_seq[i-1]));
      @(negedge clkin);
      chk("row_step", 32'(row_out), 32'(row_seq[i]));
    end
    chk("idle_pulses", 32'(pulses), 32'd0);
    chk("idle_data", data_out, 32'h0);

    // Clean press of row 2 / col 1.
    press_key(9);
    chk("data_9", data_out, 32'h00000009);

    // Press bounce on key 5: one-tick low windows never accepted.
    p0 = pulses;
    for (int i = 0; i < 8; i++) begin
      keys[5] = 1'b1; repeat (4) @(negedge clkin);
      keys[5] = 1'b0; repeat (4) @(negedge clkin);
    end
    chk("bounce_nopulse", 32'(pulses), 32'(p0));
    keys[5] = 1'b1;
    wait_valid("bounce_tmo");
    chk("bounce_code", 32'(key_code), 32'h5);
    // Release bounce inside DEB_REL.
    for (int i = 0; i < 4; i++) begin
      keys[5] = 1'b0; repeat (4) @(negedge clkin);
      keys[5] = 1'b1; repeat (4) @(negedge clkin);
    end
    chk("relbounce_held", 32'(key_held), 32'd1);
    keys[5] = 1'b0;
    wait_release("relbounce_tmo");
    chk("bounce_one", 32'(pulses), 32'(p0 + 1));
    chk("data_95", data_out, 32'h00000095);

    // Row 1 with cols 0 and 3 together; extra keys while held ignored.
    p0 = pulses;
    keys[4] = 1'b1; keys[7] = 1'b1;
    wait_valid("multi_tmo");
    chk("multi_code", 32'(key_code), 32'h4);
    keys[6] = 1'b1; keys[9] = 1'b1;
    repeat (40) @(negedge clkin);
    chk("held_ignore", 32'(pulses), 32'(p0 + 1));
    keys = '0;
    wait_release("multi_rel_tmo");
    chk("data_954", data_out, 32'h00000954);

    // Nine-key sequence wraps the shift register.
    do_reset();
    exp_data = 32'h0;
    p0 = pulses;
    foreach (seq[i]) press_key(seq[i]);
    chk("seq_data", data_out, 32'h23ABCDE0);
    chk("seq_pulses", 32'(pulses), 32'(p0 + 9));

    // Key F: clear key when enabled, else an ordinary digit.
    press_key(15);
`ifdef KEYPAD_CLR_KEY_EN
    chk("clr_data", data_out, 32'h0);
`else
    chk("f_data", data_out, 32'h3ABCDE0F);
`endif

    // Reset while debouncing a press.
    p0 = pulses;
    keys[9] = 1'b1;
    begin
      bit got = 0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clkin);
        if (row_out == 4'b1011) begin got = 1; break; end
      end
      chk("deb_row_tmo", 32'(got), 32'd1);
    end
    repeat (8) @(negedge clkin);
    chk("deb_nopulse", 32'(pulses), 32'(p0));
    reset = 1'b1; keys = '0;
    @(negedge clkin);
    chk("mid_rst_row", 32'(row_out), 32'h0000000E);
    chk("mid_rst_held", 32'(key_held), 32'h0);
    chk("mid_rst_data", data_out, 32'h0);
    chk("mid_rst_valid", 32'(key_valid), 32'h0);
    reset = 1'b0;
    repeat (40) @(negedge clkin);
    chk("mid_rst_pulses", 32'(pulses), 32'(p0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
